llvga_stream: RTL and testbench
===============================

Name: llvga_stream

Overview:
- Parametrised next-generation low-level VGA/DVI timing engine and pixel output stage.
- Generates hsync/vsync/data-enable from programmable mode registers.
- Pulls pixels from an AXI-stream-style valid/ready source, with explicit line markers and underflow/line-error reporting.
- Mode changes are double-buffered and take effect only at frame boundaries. Sits between the framebuffer reader and the DAC/TMDS encoder.

Parameters:
- BPC, 8, bits per colour channel; pixel word is 3*BPC bits, red in the MSBs.
- LGDIM, 12, width of all position counters and mode fields.
- OPT_FIRST_FRAME_SKIP, 1, when 1 suppress o_pix_ready until the first o_newframe after reset.

Ports:
- i_pixclk  in  1  pixel clock.
- i_reset_n  in  1  synchronous active-low reset.
- i_hm_width, i_hm_porch, i_hm_synch, i_hm_raw  in  LGDIM each  horizontal: active, sync start, sync end, total.
- i_vm_height, i_vm_porch, i_vm_synch, i_vm_raw  in  LGDIM each  vertical equivalents, in lines.
- i_hpol, i_vpol  in  1 each  sync polarity; 1 = active-high.
- i_mode_stb  in  1  capture the mode inputs into the pending shadow.
- o_mode_pend  out  1  pending mode not yet applied.
- o_mode_err  out  1  one-cycle pulse: strobed mode rejected.
- i_pix_valid  in  1  source pixel valid.
- o_pix_ready  out  1  sink accepts a pixel this cycle.
- i_pix_data  in  3*BPC  RGB pixel.
- i_pix_last  in  1  marks the last pixel of a line.
- o_newline  out  1  one-cycle pulse after the last active pixel of each visible line.
- o_newframe  out  1  one-cycle pulse after the last active pixel of the frame.
- o_underflow  out  1  one-cycle pulse per missed pixel.
- o_linerr  out  1  one-cycle pulse on an i_pix_last mismatch.
- o_hsync, o_vsync  out  1 each  sync outputs, polarity applied.
- o_de  out  1  data enable, aligned with the colour outputs.
- o_red, o_grn, o_blu  out  BPC each  colour outputs.

Behaviour:
- Reset (i_reset_n=0 at a clock edge):
  - hpos=vpos=0; active mode and polarity load directly from the inputs; pending cleared.
  - first_frame=1.
  - All pulse outputs, o_de, o_pix_ready and colours = 0.
  - o_hsync=!i_hpol, o_vsync=!i_vpol (inactive level).
  - Reset is honoured mid-line and mid-frame with no partial output.
- Counters:
  - hpos increments each clock and wraps from raw_h-1 to 0.
  - vpos increments when hpos wraps and itself wraps from raw_v-1 to 0.
  - All comparisons are unsigned LGDIM bits against the active (shadow) mode.
- Active region: act = (hpos<width) && (vpos<height).
- o_pix_ready: combinational, = act && !first_frame. Equals act when OPT_FIRST_FRAME_SKIP=0.
- Output stage (1-cycle latency from the counter cycle), all outputs registered:
  - o_de <= act.
  - Colours <= i_pix_data when (ready && valid), else 0.
  - o_hsync <= hpol ^ !(porch_h<=hpos<synch_h).
  - o_vsync <= vpol ^ !(porch_v<=vpos<synch_v).
- o_underflow <= ready && !valid. The missing pixel is shown black and is never "caught up".
- o_linerr <= (ready && valid) && (i_pix_last != (hpos==width-1)).
- o_newline <= (hpos==width-1) && (vpos<height).
- o_newframe <= (hpos==width-1) && (vpos==height-1). It coincides with the final o_newline.
- first_frame clears on the cycle o_newframe is registered high.
- Mode strobe:
  - On i_mode_stb, the inputs are checked: width<porch<synch<raw, and the same vertically.
  - Pass: copy into the pending shadow and set o_mode_pend.
  - Fail: pulse o_mode_err and leave pending untouched.
  - A strobe while pending overwrites the pending values (last wins).
- Mode apply:
  - At frame wrap (hpos==raw_h-1 && vpos==raw_v-1) with pending set, the active mode loads from pending, pending clears, and first_frame is set again.
  - A strobe in the same cycle as the apply captures into pending and is applied next frame.
- The timing engine never stalls: the pixel source must keep up.

Decomposition:
- Shared package (vga_pkg):
  - mode record typedef {width, porch, synch, raw} at LGDIM bits.
  - mode_valid() check function.
  - Reference mode constants: 640x480@60 h 640/656/752/800, v 480/490/492/525.
- One sub-module: llvga_modereg, holding the pending/active shadow registers, the validity check, mode_pend and mode_err.
- The counters and output stage remain in the top level.

Test Plan:
- Small mode h 16/18/20/24, v 16/17/19/20, pol 1/1, source always valid with correct last:
  - No o_pix_ready during the first 480 clocks.
  - Then exactly 256 accepts per frame; o_de high for 16 clocks per visible line.
  - o_hsync high for 2 clocks starting at hpos 18 (+1 latency).
  - o_vsync high on lines 17-18.
  - One o_newframe per 480 clocks.
- Same mode with i_pix_valid dropped for 3 cycles mid-line: 3 o_underflow pulses, 3 black pixels, o_de still high, no o_linerr.
- i_pix_last asserted on pixel 10 of a line: one o_linerr pulse; line and frame timing unchanged.
- Strobe mode h 32/34/36/40 mid-frame: o_mode_pend=1 until the frame wrap; then the new line period is 40 clocks and ready is suppressed for one frame.
- Strobe an invalid mode (porch 10 < width 16): o_mode_err pulses once, o_mode_pend stays 0, timing unchanged.
- i_hpol=0, and reset asserted mid-line:
  - During reset: o_hsync=1 idle, all outputs zeroed, hpos and vpos restart at 0.
  - After release, the first hsync pulse is low.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared mode record, mode validity check and reference timings
package vga_pkg;
   // Mode fields are held at a fixed 16 bits so one record type serves any LGDIM up to 16
   localparam int MW = 16;
   typedef struct packed {
      logic [MW-1:0] width;
      logic [MW-1:0] porch;
      logic [MW-1:0] synch;
      logic [MW-1:0] raw;
   } mode_t;
   function automatic logic mode_valid(input mode_t m);
      return (m.width < m.porch) && (m.porch < m.synch) && (m.synch < m.raw);
   endfunction
   localparam mode_t VGA640_H = '{width: 16'd640, porch: 16'd656, synch: 16'd752, raw: 16'd800};
   localparam mode_t VGA640_V = '{width: 16'd480, porch: 16'd490, synch: 16'd492, raw: 16'd525};
endpackage

// File: rtl/llvga_modereg.sv
// llvga_modereg: pending/active mode shadows, strobe validation and frame-boundary apply
module llvga_modereg import vga_pkg::*; (
   input  logic  i_pixclk,
   input  logic  i_reset_n,
   input  logic  i_mode_stb,
   input  logic  i_apply,
   input  mode_t i_hm,
   input  mode_t i_vm,
   input  logic  i_hpol,
   input  logic  i_vpol,
   output mode_t o_hm,
   output mode_t o_vm,
   output logic  o_hpol,
   output logic  o_vpol,
   output logic  o_mode_pend,
   output logic  o_mode_err
);
   mode_t pnd_h, pnd_v;
   logic  pnd_hpol, pnd_vpol, ok;
   assign ok = mode_valid(i_hm) && mode_valid(i_vm);
   // Apply uses the old pending values, so a strobe on the apply cycle waits for the next frame
   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         o_hm        <= i_hm;
         o_vm        <= i_vm;
         o_hpol      <= i_hpol;
         o_vpol      <= i_vpol;
         pnd_h       <= '0;
         pnd_v       <= '0;
         pnd_hpol    <= 1'b0;
         pnd_vpol    <= 1'b0;
         o_mode_pend <= 1'b0;
         o_mode_err  <= 1'b0;
      end else begin
         o_mode_err <= i_mode_stb && !ok;
         if (i_apply && o_mode_pend) begin
            o_hm   <= pnd_h;
            o_vm   <= pnd_v;
            o_hpol <= pnd_hpol;
            o_vpol <= pnd_vpol;
         end
         if (i_mode_stb && ok) begin
            pnd_h       <= i_hm;
            pnd_v       <= i_vm;
            pnd_hpol    <= i_hpol;
            pnd_vpol    <= i_vpol;
            o_mode_pend <= 1'b1;
         end else if (i_apply) begin
            o_mode_pend <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/llvga_stream.sv
// llvga_stream: VGA/DVI timing engine pulling pixels from a valid/ready stream
module llvga_stream import vga_pkg::*; #(
   parameter int BPC                  = 8,
   parameter int LGDIM                = 12,
   parameter bit OPT_FIRST_FRAME_SKIP = 1'b1
) (
   input  logic             i_pixclk,
   input  logic             i_reset_n,
   input  logic [LGDIM-1:0] i_hm_width,
   input  logic [LGDIM-1:0] i_hm_porch,
   input  logic [LGDIM-1:0] i_hm_synch,
   input  logic [LGDIM-1:0] i_hm_raw,
   input  logic [LGDIM-1:0] i_vm_height,
   input  logic [LGDIM-1:0] i_vm_porch,
   input  logic [LGDIM-1:0] i_vm_synch,
   input  logic [LGDIM-1:0] i_vm_raw,
   input  logic             i_hpol,
   input  logic             i_vpol,
   input  logic             i_mode_stb,
   output logic             o_mode_pend,
   output logic             o_mode_err,
   input  logic             i_pix_valid,
   output logic             o_pix_ready,
   input  logic [3*BPC-1:0] i_pix_data,
   input  logic             i_pix_last,
   output logic             o_newline,
   output logic             o_newframe,
   output logic             o_underflow,
   output logic             o_linerr,
   output logic             o_hsync,
   output logic             o_vsync,
   output logic             o_de,
   output logic [BPC-1:0]   o_red,
   output logic [BPC-1:0]   o_grn,
   output logic [BPC-1:0]   o_blu
);
   mode_t hin, vin, hm, vm;
   logic hpol, vpol;
   logic [LGDIM-1:0] hpos, vpos;
   logic [MW-1:0] hx, vx;
   logic act, hlast, vlast, hwrap, vwrap, fwrap, ready, take, first_frame;
   assign hin = '{width: MW'(i_hm_width), porch: MW'(i_hm_porch), synch: MW'(i_hm_synch), raw: MW'(i_hm_raw)};
   assign vin = '{width: MW'(i_vm_height), porch: MW'(i_vm_porch), synch: MW'(i_vm_synch), raw: MW'(i_vm_raw)};
   llvga_modereg u_modereg (
      .i_pixclk    (i_pixclk),
      .i_reset_n   (i_reset_n),
      .i_mode_stb  (i_mode_stb),
      .i_apply     (fwrap),
      .i_hm        (hin),
      .i_vm        (vin),
      .i_hpol      (i_hpol),
      .i_vpol      (i_vpol),
      .o_hm        (hm),
      .o_vm        (vm),
      .o_hpol      (hpol),
      .o_vpol      (vpol),
      .o_mode_pend (o_mode_pend),
      .o_mode_err  (o_mode_err)
   );
   assign hx    = MW'(hpos);
   assign vx    = MW'(vpos);
   assign act   = (hx < hm.width) && (vx < vm.width);
   assign hlast = hx == hm.width - MW'(1);
   assign vlast = vx == vm.width - MW'(1);
   assign hwrap = hx == hm.raw - MW'(1);
   assign vwrap = vx == vm.raw - MW'(1);
   assign fwrap = hwrap && vwrap;
   assign ready = act && !(OPT_FIRST_FRAME_SKIP && first_frame);
   assign take  = ready && i_pix_valid;
   assign o_pix_ready = ready;
   // Free-running raster position against the active mode
   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         hpos <= '0;
         vpos <= '0;
      end else begin
         hpos <= hwrap ? '0 : hpos + 1'b1;
         if (hwrap)
            vpos <= vwrap ? '0 : vpos + 1'b1;
      end
   end
   // Hold off the source for one whole frame after reset or a mode change
   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n)
         first_frame <= 1'b1;
      else if (fwrap && o_mode_pend)
         first_frame <= 1'b1;
      else if (hlast && vlast)
         first_frame <= 1'b0;
   end
   // Registered output stage, one clock behind the raster position
   always_ff @(posedge i_pixclk) begin
      if (!i_reset_n) begin
         o_de                  <= 1'b0;
         {o_red, o_grn, o_blu} <= '0;
         o_hsync               <= !i_hpol;
         o_vsync               <= !i_vpol;
         o_newline             <= 1'b0;
         o_newframe            <= 1'b0;
         o_underflow           <= 1'b0;
         o_linerr              <= 1'b0;
      end else begin
         o_de                  <= act;
         {o_red, o_grn, o_blu} <= take ? i_pix_data : '0;
         o_hsync               <= hpol ^ !((hx >= hm.porch) && (hx < hm.synch));
         o_vsync               <= vpol ^ !((vx >= vm.porch) && (vx < vm.synch));
         o_newline             <= hlast && (vx < vm.width);
         o_newframe            <= hlast && vlast;
         o_underflow           <= ready && !i_pix_valid;
         o_linerr              <= take && (i_pix_last != hlast);
      end
   end
endmodule

// File: tb/tb_llvga_stream.sv
// tb_llvga_stream: directed checks of raster timing, stream handshake, mode changes and reset
module tb_llvga_stream;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [11:0] hw, hp, hs, hr, vh, vp, vs, vr;
   logic hpol = 1'b1, vpol = 1'b1, stb = 1'b0, valid = 1'b1, last = 1'b0;
   logic [23:0] data = '0;
   logic pend, err, ready, nl, nf, uf, le, hsync, vsync, de;
   logic [7:0] red, grn, blu;
   int n, slot, tw, cmp, bad;
   int acc, de_c, nf_c, nl_c, uf_c, le_c, hs_c, vs_c, er_c, bk_c;
   bit rdy_q, ufl, inj;
   always #5 clk = ~clk;
   llvga_stream dut (
      .i_pixclk(clk), .i_reset_n(rst_n),
      .i_hm_width(hw), .i_hm_porch(hp), .i_hm_synch(hs), .i_hm_raw(hr),
      .i_vm_height(vh), .i_vm_porch(vp), .i_vm_synch(vs), .i_vm_raw(vr),
      .i_hpol(hpol), .i_vpol(vpol), .i_mode_stb(stb),
      .o_mode_pend(pend), .o_mode_err(err),
      .i_pix_valid(valid), .o_pix_ready(ready), .i_pix_data(data), .i_pix_last(last),
      .o_newline(nl), .o_newframe(nf), .o_underflow(uf), .o_linerr(le),
      .o_hsync(hsync), .o_vsync(vsync), .o_de(de),
      .o_red(red), .o_grn(grn), .o_blu(blu)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask
   // Source: one slot per ready cycle, last on slot tw-1, optional injected faults
   task automatic drive();
      last  = (slot == tw - 1) || (inj && slot == 10);
      valid = !(ufl && slot >= 5 && slot <= 7);
      data  = 24'h804000 | 24'(slot);
      if (ready) begin
         if (slot == 10) inj = 1'b0;
         if (slot == 7) ufl = 1'b0;
         slot = (slot + 1) % tw;
      end
      rdy_q = ready && valid;
   endtask
   task automatic step();
      @(posedge clk);
      n++;
      @(negedge clk);
      acc  += int'(rdy_q);
      de_c += int'(de);
      nf_c += int'(nf);
      nl_c += int'(nl);
      uf_c += int'(uf);
      le_c += int'(le);
      hs_c += int'(hsync);
      vs_c += int'(vsync);
      er_c += int'(err);
      if (de && {red, grn, blu} == 24'h0) bk_c++;
      drive();
   endtask
   task automatic upto(input int t);
      while (n < t + 1) step();
   endtask
   task automatic clr();
      acc = 0; de_c = 0; nf_c = 0; nl_c = 0; uf_c = 0;
      le_c = 0; hs_c = 0; vs_c = 0; er_c = 0; bk_c = 0;
   endtask
   task automatic small_mode();
      hw = 16; hp = 18; hs = 20; hr = 24;
      vh = 16; vp = 17; vs = 19; vr = 20;
   endtask
   task automatic reset_on();
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask
   task automatic reset_off();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      n = 0; slot = 0; tw = 16; inj = 1'b0; ufl = 1'b0;
      drive();
   endtask
   initial begin
      cmp = 0; bad = 0; tw = 16; slot = 0;
      small_mode();
      reset_on();
      chk("rst_hsync", 32'(hsync), 0);
      chk("rst_vsync", 32'(vsync), 0);
      chk("rst_de", 32'(de), 0);
      chk("rst_rgb", 32'({red, grn, blu}), 0);
      chk("rst_ready", 32'(ready), 0);
      chk("rst_pend", 32'(pend), 0);
      chk("rst_newframe", 32'(nf), 0);
      reset_off();
      clr();
      upto(479);
      chk("f0_accepts", acc, 0);
      chk("f0_de", de_c, 256);
      chk("f0_newframe", nf_c, 1);
      clr();
      upto(483);
      chk("f1_pix3", 32'({red, grn, blu}), 32'h804003);
      upto(495);
      chk("f1_pix15", 32'({red, grn, blu}), 32'h80400F);
      upto(496);
      chk("f1_hblank_de", 32'(de), 0);
      chk("f1_hblank_rgb", 32'({red, grn, blu}), 0);
      upto(959);
      chk("f1_accepts", acc, 256);
      chk("f1_de", de_c, 256);
      chk("f1_newframe", nf_c, 1);
      chk("f1_newline", nl_c, 16);
      chk("f1_hsync", hs_c, 40);
      chk("f1_vsync", vs_c, 48);
      chk("f1_underflow", uf_c, 0);
      chk("f1_linerr", le_c, 0);
      chk("f1_black", bk_c, 0);
      upto(977);
      chk("hs_before", 32'(hsync), 0);
      upto(978);
      chk("hs_start", 32'(hsync), 1);
      upto(979);
      chk("hs_second", 32'(hsync), 1);
      upto(980);
      chk("hs_end", 32'(hsync), 0);
      upto(1367);
      chk("vs_before", 32'(vsync), 0);
      upto(1368);
      chk("vs_line17", 32'(vsync), 1);
      upto(1439);
      clr();
      ufl = 1'b1;
      upto(1919);
      chk("uf_pulses", uf_c, 3);
      chk("uf_black", bk_c, 3);
      chk("uf_de", de_c, 256);
      chk("uf_linerr", le_c, 0);
      chk("uf_accepts", acc, 253);
      clr();
      inj = 1'b1;
      upto(2399);
      chk("le_pulses", le_c, 1);
      chk("le_newframe", nf_c, 1);
      chk("le_newline", nl_c, 16);
      chk("le_accepts", acc, 256);
      chk("le_hsync", hs_c, 40);
      clr();
      upto(2500);
      hp = 10;
      stb = 1'b1;
      step();
      chk("bad_err", 32'(err), 1);
      chk("bad_pend", 32'(pend), 0);
      stb = 1'b0;
      hp = 18;
      step();
      chk("bad_err_clear", 32'(err), 0);
      upto(2879);
      chk("bad_err_count", er_c, 1);
      chk("bad_newframe", nf_c, 1);
      chk("bad_accepts", acc, 256);
      chk("bad_hsync", hs_c, 40);
      upto(3000);
      hw = 32; hp = 34; hs = 36; hr = 40;
      stb = 1'b1;
      step();
      chk("new_pend", 32'(pend), 1);
      chk("new_err", 32'(err), 0);
      stb = 1'b0;
      upto(3358);
      chk("new_pend_hold", 32'(pend), 1);
      upto(3359);
      chk("new_pend_apply", 32'(pend), 0);
      tw = 32;
      clr();
      upto(4159);
      chk("g0_accepts", acc, 0);
      chk("g0_de", de_c, 512);
      chk("g0_newframe", nf_c, 1);
      chk("g0_newline", nl_c, 16);
      clr();
      upto(4193);
      chk("g1_hs_before", 32'(hsync), 0);
      upto(4194);
      chk("g1_hs_start", 32'(hsync), 1);
      upto(4196);
      chk("g1_hs_end", 32'(hsync), 0);
      upto(4234);
      chk("g1_hs_line1", 32'(hsync), 1);
      upto(4959);
      chk("g1_accepts", acc, 512);
      chk("g1_linerr", le_c, 0);
      chk("g1_newframe", nf_c, 1);
      chk("g1_hsync", hs_c, 40);
      small_mode();
      hpol = 1'b0;
      upto(5049);
      reset_on();
      chk("mid_rst_hsync", 32'(hsync), 1);
      chk("mid_rst_vsync", 32'(vsync), 0);
      chk("mid_rst_de", 32'(de), 0);
      chk("mid_rst_rgb", 32'({red, grn, blu}), 0);
      chk("mid_rst_ready", 32'(ready), 0);
      chk("mid_rst_newline", 32'(nl), 0);
      reset_off();
      upto(15);
      chk("post_newline", 32'(nl), 1);
      chk("post_hs_idle", 32'(hsync), 1);
      upto(17);
      chk("post_hs_before", 32'(hsync), 1);
      upto(18);
      chk("post_hs_low", 32'(hsync), 0);
      upto(19);
      chk("post_hs_low2", 32'(hsync), 0);
      upto(20);
      chk("post_hs_end", 32'(hsync), 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
      $finish;
   end
endmodule
